// File: rtl/move_arbiter_if.sv
// Player-facing bus of the stick-game move arbiter: raw button requests in,
// game status out.
interface move_arbiter_if;
  logic        start;
  logic        p0_req;
  logic [3:0]  p0_take;
  logic        p1_req;
  logic [3:0]  p1_take;
  logic [15:0] sticks;
  logic        turn;
  logic        grant;
  logic        wrong;
  logic        finish;
  logic        winner;
  logic        active;

  modport master (
    output start, p0_req, p0_take, p1_req, p1_take,
    input  sticks, turn, grant, wrong, finish, winner, active
  );

  modport slave (
    input  start, p0_req, p0_take, p1_req, p1_take,
    output sticks, turn, grant, wrong, finish, winner, active
  );
endinterface

// File: rtl/move_arbiter.sv
// Two-player take-away stick game: debounces the current player's button,
// validates the requested take and tracks sticks, turn and the winner.
module move_arbiter #(
  parameter int INIT_STICKS = 100,
  parameter int MAX_TAKE    = 9,
  parameter int DEB_CYCLES  = 64
) (
  input  logic           clk,
  input  logic           rst,
  move_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REQ,
    QUAL,
    APPLY,
    RELEASE,
    DONE
  } state_t;

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [3:0]        take_q, take_n;
  logic [15:0]       sticks_q, sticks_n;
  logic              turn_q, turn_n;
  logic              wrong_q, wrong_n;
  logic              finish_q, finish_n;
  logic              winner_q, winner_n;
  logic              grant_q, grant_n;

  logic              cur_req;
  logic [3:0]        cur_take;
  logic [15:0]       take_ext;
  logic              legal;

  // Only the player whose turn it is can be heard.
  always_comb begin
    cur_req  = turn_q ? bus.p1_req  : bus.p0_req;
    cur_take = turn_q ? bus.p1_take : bus.p0_take;
    take_ext = {12'd0, take_q};
    legal    = (take_q != 4'd0) && (take_ext <= 16'(MAX_TAKE)) && (take_ext <= sticks_q);
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    take_n   = take_q;
    sticks_n = sticks_q;
    turn_n   = turn_q;
    wrong_n  = wrong_q;
    finish_n = finish_q;
    winner_n = winner_q;
    grant_n  = 1'b0;

    if (bus.start) begin
      state_n  = WAIT_REQ;
      cnt_n    = '0;
      sticks_n = 16'(INIT_STICKS);
      turn_n   = 1'b0;
      wrong_n  = 1'b0;
      finish_n = 1'b0;
      winner_n = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        WAIT_REQ: begin
          if (cur_req) begin
            if (DEB_CYCLES <= 1) begin
              take_n  = cur_take;
              state_n = APPLY;
            end else begin
              cnt_n   = CNT_W'(1);
              state_n = QUAL;
            end
          end
        end
        QUAL: begin
          if (!cur_req) begin
            cnt_n   = '0;
            state_n = WAIT_REQ;
          end else if (cnt_q >= CNT_W'(DEB_CYCLES - 1)) begin
            take_n  = cur_take;
            cnt_n   = '0;
            state_n = APPLY;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        APPLY: begin
          if (legal) begin
            sticks_n = sticks_q - take_ext;
            wrong_n  = 1'b0;
            grant_n  = 1'b1;
            if (take_ext == sticks_q) begin
              finish_n = 1'b1;
              winner_n = ~turn_q;
              state_n  = DONE;
            end else begin
              turn_n  = ~turn_q;
              state_n = RELEASE;
            end
          end else begin
            wrong_n = 1'b1;
            state_n = RELEASE;
          end
        end
        // A held button must be let go before another move can start.
        RELEASE: begin
          if (!bus.p0_req && !bus.p1_req) state_n = WAIT_REQ;
        end
        DONE: ;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sticks_q <= 16'(INIT_STICKS);
      turn_q   <= 1'b0;
      wrong_q  <= 1'b0;
      finish_q <= 1'b0;
      winner_q <= 1'b0;
      grant_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      sticks_q <= sticks_n;
      turn_q   <= turn_n;
      wrong_q  <= wrong_n;
      finish_q <= finish_n;
      winner_q <= winner_n;
      grant_q  <= grant_n;
    end
  end

  always_ff @(posedge clk) begin
    take_q <= take_n;
  end

  assign bus.sticks = sticks_q;
  assign bus.turn   = turn_q;
  assign bus.grant  = grant_q;
  assign bus.wrong  = wrong_q;
  assign bus.finish = finish_q;
  assign bus.winner = winner_q;
  assign bus.active = (state_q == WAIT_REQ) || (state_q == QUAL) ||
                      (state_q == APPLY)    || (state_q == RELEASE);

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: directed game scenarios plus random button bursts,
// all checked cycle by cycle against a rule-level game model.
module tb_move_arbiter;
  localparam int DEB  = 4;
  localparam int INIT = 100;
  localparam int MAXT = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_arbiter_if bus();

  move_arbiter #(
    .INIT_STICKS(INIT),
    .MAX_TAKE   (MAXT),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Game model: a move is a run of DEB consecutive high samples from the
  // player on turn; it takes effect one edge later; then both buttons must
  // be seen released before a new run counts.
  int m_sticks, m_run, m_take;
  bit m_turn, m_wrong, m_finish, m_winner, m_grant, m_active, m_commit, m_hold;

  task automatic model_step();
    bit cr;
    m_grant = 1'b0;
    if (rst) begin
      m_sticks = INIT; m_turn = 0; m_wrong = 0; m_finish = 0; m_winner = 0;
      m_active = 0; m_commit = 0; m_hold = 0; m_run = 0;
    end else if (bus.start) begin
      m_sticks = INIT; m_turn = 0; m_wrong = 0; m_finish = 0; m_winner = 0;
      m_active = 1; m_commit = 0; m_hold = 0; m_run = 0;
    end else if (!m_active) begin
      // idle or game over: nothing moves
    end else if (m_commit) begin
      m_commit = 0;
      if (m_take >= 1 && m_take <= MAXT && m_take <= m_sticks) begin
        m_sticks = m_sticks - m_take;
        m_grant  = 1;
        m_wrong  = 0;
        if (m_sticks == 0) begin
          m_finish = 1;
          m_winner = !m_turn;
          m_active = 0;
        end else begin
          m_turn = !m_turn;
          m_hold = 1;
        end
      end else begin
        m_wrong = 1;
        m_hold  = 1;
      end
    end else if (m_hold) begin
      if (!bus.p0_req && !bus.p1_req) m_hold = 0;
    end else begin
      cr = m_turn ? bus.p1_req : bus.p0_req;
      if (cr) begin
        m_run++;
        if (m_run == DEB) begin
          m_commit = 1;
          m_take   = m_turn ? int'(bus.p1_take) : int'(bus.p0_take);
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("sticks", bus.sticks, m_sticks);
    check("turn",   bus.turn,   m_turn);
    check("grant",  bus.grant,  m_grant);
    check("wrong",  bus.wrong,  m_wrong);
    check("finish", bus.finish, m_finish);
    check("active", bus.active, m_active);
    if (m_finish) check("winner", bus.winner, m_winner);
  endtask

  int grants;

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (bus.grant) grants++;
  endtask

  task automatic drive(input bit s, input bit r0, input int t0, input bit r1, input int t1);
    bus.start   = s;
    bus.p0_req  = r0;
    bus.p0_take = 4'(t0);
    bus.p1_req  = r1;
    bus.p1_take = 4'(t1);
  endtask

  task automatic do_move(input bit p, input int take, input int hi);
    for (int i = 0; i < hi; i++) begin
      if (p) drive(0, 0, 0, 1, take);
      else   drive(0, 1, take, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
  endtask

  int g0, grant_at;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_sticks", bus.sticks, 100);
    check("rst_active", bus.active, 0);

    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();

    // First move: grant lands on the 5th edge after the first high sample.
    g0 = grants; grant_at = 0;
    for (int i = 1; i <= 6; i++) begin
      drive(0, 1, 5, 0, 0);
      tick();
      if (bus.grant) grant_at = i;
    end
    drive(0, 0, 0, 0, 0); tick(); tick();
    check("m1_grants", grants - g0, 1);
    check("m1_grant_edge", grant_at, 5);
    check("m1_sticks", bus.sticks, 95);
    check("m1_turn", bus.turn, 1);

    // Out-of-turn player is ignored; then an illegal zero take.
    g0 = grants;
    do_move(0, 3, 10);
    check("oot_grants", grants - g0, 0);
    check("oot_sticks", bus.sticks, 95);
    do_move(1, 0, 6);
    check("zero_wrong", bus.wrong, 1);
    check("zero_turn", bus.turn, 1);

    // Glitchy button never qualifies.
    g0 = grants;
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 1, 2); tick(); end
    drive(0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 2); tick(); end
    drive(0, 0, 0, 0, 0); tick(); tick();
    check("glitch_grants", grants - g0, 0);
    check("glitch_sticks", bus.sticks, 95);

    // Play a game down to the end.
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 10; k++) do_move(k[0], 9, 6);
    check("g_sticks10", bus.sticks, 10);
    do_move(0, 3, 6);
    do_move(1, 8, 6);
    check("over_sticks_wrong", bus.wrong, 1);
    check("over_sticks_keep", bus.sticks, 7);
    do_move(1, 10, 6);
    check("over_max_wrong", bus.wrong, 1);
    do_move(1, 3, 6);
    check("g_sticks4", bus.sticks, 4);
    check("g_turn0", bus.turn, 0);
    do_move(0, 4, 6);
    check("end_sticks", bus.sticks, 0);
    check("end_finish", bus.finish, 1);
    check("end_winner", bus.winner, 1);
    check("end_active", bus.active, 0);
    g0 = grants;
    do_move(1, 2, 6);
    do_move(0, 2, 6);
    check("done_frozen", grants - g0, 0);
    drive(1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick();
    check("reload_sticks", bus.sticks, 100);
    check("reload_finish", bus.finish, 0);

    // Reset during qualification; reset and start racing a commit.
    for (int i = 0; i < 2; i++) begin drive(0, 1, 2, 0, 0); tick(); end
    rst = 1'b1; drive(0, 1, 2, 0, 0); tick();
    rst = 1'b0; drive(0, 0, 0, 0, 0); tick();
    check("rq_active", bus.active, 0);
    check("rq_sticks", bus.sticks, 100);
    drive(1, 0, 0, 0, 0); tick();
    g0 = grants;
    for (int i = 0; i < 3; i++) begin drive(0, 1, 2, 0, 0); tick(); end
    drive(1, 1, 2, 0, 0); tick();
    drive(0, 0, 0, 0, 0); tick(); tick();
    check("sq_grants", grants - g0, 0);
    check("sq_sticks", bus.sticks, 100);
    for (int i = 0; i < 4; i++) begin drive(0, 1, 2, 0, 0); tick(); end
    rst = 1'b1; drive(0, 1, 2, 0, 0); tick();
    rst = 1'b0; drive(0, 0, 0, 0, 0); tick();
    check("ra_grants", grants - g0, 0);
    check("ra_sticks", bus.sticks, 100);

    // Random bursts.
    drive(1, 0, 0, 0, 0); tick();
    for (int n = 0; n < 300; n++) begin
      int r, take, hi, lo;
      bit p, other;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst = 1'b1; drive(0, $urandom_range(0, 1), 3, 0, 0); tick(); rst = 1'b0;
      end else if (r < 8) begin
        drive(1, $urandom_range(0, 1), 3, $urandom_range(0, 1), 3); tick();
      end else begin
        p     = 1'($urandom_range(0, 1));
        other = ($urandom_range(0, 9) == 0);
        take  = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 9) : $urandom_range(0, 15);
        hi    = $urandom_range(0, 8);
        lo    = $urandom_range(0, 3);
        for (int i = 0; i < hi; i++) begin
          if (p) drive(0, other, take, 1, take);
          else   drive(0, 1, take, other, take);
          tick();
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < lo; i++) tick();
      end
    end
    drive(0, 0, 0, 0, 0); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
